game_state_uart_tx: RTL and testbench

//  Transmit side of the inter-board game-state link. On each frame tick, snapshots

---
 rtl/game_state_uart_tx_pkg.sv | 70 +++++++
 rtl/game_state_uart_tx_byte_tx.sv | 118 +++++++++++
 rtl/game_state_uart_tx.sv | 124 ++++++++++++
 tb/tb_game_state_uart_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_uart_tx_pkg.sv
// Shared definitions for the inter-board game-state link.
// Used by the transmitter (game_state_uart_tx) and by the matching receiver
// on the remote board, so packet layout and FSM encodings live here only.
//   HEADER_DEFAULT : packet sync byte
//   PKT_BYTES      : bytes per packet (header + 5 payload + checksum)
//   IDX_*          : byte positions inside the packet
//   pkt_state_e    : packet framer states
//   btx_state_e    : byte serializer states
//   snapshot_t     : latched game state carried by one packet
//   pkt_byte()     : byte value at a given packet position
package game_state_uart_tx_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         PKT_BYTES      = 7;

  localparam logic [2:0] IDX_HDR   = 3'd0;
  localparam logic [2:0] IDX_XHI   = 3'd1;
  localparam logic [2:0] IDX_XLO   = 3'd2;
  localparam logic [2:0] IDX_YHI   = 3'd3;
  localparam logic [2:0] IDX_YLO   = 3'd4;
  localparam logic [2:0] IDX_SCORE = 3'd5;
  localparam logic [2:0] IDX_CHK   = 3'd6;
  localparam logic [2:0] IDX_LAST  = 3'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_LOAD,
    PKT_SEND,
    PKT_DONE
  } pkt_state_e;

  typedef enum logic [1:0] {
    BTX_IDLE,
    BTX_START,
    BTX_DATA,
    BTX_STOP
  } btx_state_e;

  typedef struct packed {
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [3:0]  p1;
    logic [3:0]  p2;
  } snapshot_t;

  // XOR of the five payload bytes; the header is deliberately excluded.
  function automatic logic [7:0] pkt_checksum(input snapshot_t s);
    return {4'h0, s.xpos[11:8]} ^ s.xpos[7:0] ^
           {4'h0, s.ypos[11:8]} ^ s.ypos[7:0] ^
           {s.p1, s.p2};
  endfunction

  function automatic logic [7:0] pkt_byte(input logic [2:0] idx,
                                          input snapshot_t  s,
                                          input logic [7:0] header);
    logic [7:0] b;
    case (idx)
      IDX_HDR:   b = header;
      IDX_XHI:   b = {4'h0, s.xpos[11:8]};
      IDX_XLO:   b = s.xpos[7:0];
      IDX_YHI:   b = {4'h0, s.ypos[11:8]};
      IDX_YLO:   b = s.ypos[7:0];
      IDX_SCORE: b = {s.p1, s.p2};
      IDX_CHK:   b = pkt_checksum(s);
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/game_state_uart_tx_byte_tx.sv
// uart_byte_tx: 8N1 serializer for a single byte.
//   clk_in  : system clock
//   rst_n   : asynchronous active-low reset (line returns to idle high)
//   start   : strobe, begins a start bit on the next cycle (honoured when ready)
//   data    : byte to send; sampled at the end of the start bit, so the
//             caller has the whole start bit to present it
//   tx      : registered serial output, idle high
//   ready   : idle, or in the final cycle of a stop bit (allows back-to-back)
//   done    : final cycle of the stop bit
module uart_byte_tx
  import game_state_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  btx_state_e    state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_q, tx_n;
  logic          bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign ready   = (state == BTX_IDLE) || ((state == BTX_STOP) && bit_end);
  assign done    = (state == BTX_STOP) && bit_end;
  assign tx      = tx_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BTX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    tx_n    = tx_q;
    case (state)
      BTX_IDLE: begin
        tx_n = 1'b1;
        if (start) begin
          state_n = BTX_START;
          baud_n  = '0;
          tx_n    = 1'b0;
        end
      end
      BTX_START: begin
        if (bit_end) begin
          state_n = BTX_DATA;
          baud_n  = '0;
          bit_n   = '0;
          shreg_n = data;
          tx_n    = data[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      BTX_DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = BTX_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      BTX_STOP: begin
        if (bit_end) begin
          baud_n = '0;
          // A start in the last stop cycle chains the next byte with no idle gap.
          if (start) begin
            state_n = BTX_START;
            tx_n    = 1'b0;
          end else begin
            state_n = BTX_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = BTX_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/game_state_uart_tx.sv
// game_state_uart_tx: transmit side of the inter-board game-state link.
// On frame_tick, snapshots ball position and scores and sends a 7-byte
// packet (header, x hi/lo, y hi/lo, scores, checksum) as 8N1 UART.
//   clk_in         : system clock
//   rst_n          : asynchronous active-low reset
//   frame_tick     : one-cycle packet request
//   xpos_ball      : ball x (12-bit unsigned)
//   ypos_ball      : ball y (12-bit unsigned)
//   player_1_score : 4-bit score
//   player_2_score : 4-bit score
//   tx             : serial line, idle high
//   busy           : packet in flight
//   pkt_done       : one-cycle pulse after the last stop bit
//   overrun        : one-cycle pulse when a tick was dropped because busy
module game_state_uart_tx
  import game_state_uart_tx_pkg::*;
#(
  parameter int         CLK_HZ = 65_000_000,
  parameter int         BAUD   = 115_200,
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [11:0] xpos_ball,
  input  logic [11:0] ypos_ball,
  input  logic [3:0]  player_1_score,
  input  logic [3:0]  player_2_score,
  output logic        tx,
  output logic        busy,
  output logic        pkt_done,
  output logic        overrun
);

  // Must come out >= 2 so the byte register is loaded before the serializer
  // samples it at the end of the start bit.
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  pkt_state_e state, state_n;
  logic [2:0] idx, idx_n;
  snapshot_t  snap, snap_n;
  logic [7:0] byte_q, byte_n;
  logic       overrun_q, overrun_n;
  logic       accept;
  logic       btx_start, btx_ready, btx_done;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PKT_IDLE;
      idx       <= IDX_HDR;
      snap      <= '0;
      byte_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      snap      <= snap_n;
      byte_q    <= byte_n;
      overrun_q <= overrun_n;
    end
  end

  // The serializer is started in the same edge that accepts the tick (or
  // finishes a byte); LOAD then fills byte_q while the start bit is on the
  // line, so byte selection costs no line time.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    snap_n    = snap;
    byte_n    = byte_q;
    btx_start = 1'b0;
    accept    = frame_tick && btx_ready &&
                ((state == PKT_IDLE) || (state == PKT_DONE));
    overrun_n = frame_tick && ((state == PKT_LOAD) || (state == PKT_SEND));
    case (state)
      PKT_IDLE, PKT_DONE: begin
        state_n = PKT_IDLE;
        if (accept) begin
          snap_n    = {xpos_ball, ypos_ball, player_1_score, player_2_score};
          idx_n     = IDX_HDR;
          state_n   = PKT_LOAD;
          btx_start = 1'b1;
        end
      end
      PKT_LOAD: begin
        byte_n  = pkt_byte(idx, snap, HEADER);
        state_n = PKT_SEND;
      end
      PKT_SEND: begin
        if (btx_done) begin
          if (idx == IDX_LAST) begin
            idx_n   = IDX_HDR;
            state_n = PKT_DONE;
          end else begin
            idx_n     = idx + 3'd1;
            state_n   = PKT_LOAD;
            btx_start = 1'b1;
          end
        end
      end
      default: begin
        state_n = PKT_IDLE;
        idx_n   = IDX_HDR;
      end
    endcase
  end

  assign busy     = (state == PKT_LOAD) || (state == PKT_SEND);
  assign pkt_done = (state == PKT_DONE);
  assign overrun  = overrun_q;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .start (btx_start),
    .data  (byte_q),
    .tx    (tx),
    .ready (btx_ready),
    .done  (btx_done)
  );

endmodule

// File: tb/tb_game_state_uart_tx.sv
module tb_game_state_uart_tx;

  localparam int CPB     = 16;
  localparam int PKT_CYC = 70 * CPB;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [11:0] xpos_ball = '0;
  logic [11:0] ypos_ball = '0;
  logic [3:0]  player_1_score = '0;
  logic [3:0]  player_2_score = '0;
  logic        tx, busy, pkt_done, overrun;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [11:0]      x;
    logic [11:0]      y;
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [0:6][7:0]  b;
  } vec_t;

  vec_t vecs[5];

  game_state_uart_tx #(
    .CLK_HZ(16),
    .BAUD  (1),
    .HEADER(8'hA5)
  ) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .xpos_ball     (xpos_ball),
    .ypos_ball     (ypos_ball),
    .player_1_score(player_1_score),
    .player_2_score(player_2_score),
    .tx            (tx),
    .busy          (busy),
    .pkt_done      (pkt_done),
    .overrun       (overrun)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [0:6][7:0] model(input logic [11:0] x, input logic [11:0] y,
                                            input logic [3:0] a, input logic [3:0] b);
    logic [0:6][7:0] r;
    r[0] = 8'hA5;
    r[1] = {4'h0, x[11:8]};
    r[2] = x[7:0];
    r[3] = {4'h0, y[11:8]};
    r[4] = y[7:0];
    r[5] = {a, b};
    r[6] = r[1] ^ r[2] ^ r[3] ^ r[4] ^ r[5];
    return r;
  endfunction

  task automatic push_bytes(input logic [0:6][7:0] b);
    for (int i = 0; i < 7; i++) exp_q.push_back(b[i]);
  endtask

  // UART receiver: samples mid-bit on negedges, pops the scoreboard per byte.
  bit         mon_active = 1'b0;
  bit         mon_ok = 1'b1;
  int         mon_cnt = 0;
  int         mon_k = 0;
  logic [7:0] mon_sh = '0;
  logic [7:0] mon_exp;

  always @(negedge clk_in) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_ok     = 1'b1;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        mon_k = mon_cnt / CPB;
        if (mon_k == 0) begin
          if (tx !== 1'b0) mon_ok = 1'b0;
        end else if (mon_k <= 8) begin
          mon_sh = {tx, mon_sh[7:1]};
        end else begin
          if (tx !== 1'b1) mon_ok = 1'b0;
          mon_active = 1'b0;
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_byte actual=%0h required=none (t=%0t)", mon_sh, $time);
          end else begin
            mon_exp = exp_q.pop_front();
            check("rx_byte{frame_ok,data}", {23'd0, mon_ok, mon_sh}, {23'd0, 1'b1, mon_exp});
          end
        end
      end
    end
  end

  task automatic pulse_tick(input logic [11:0] x, input logic [11:0] y,
                            input logic [3:0] a, input logic [3:0] b);
    @(posedge clk_in); #1;
    xpos_ball      = x;
    ypos_ball      = y;
    player_1_score = a;
    player_2_score = b;
    frame_tick     = 1'b1;
    @(posedge clk_in); #1;
    frame_tick = 1'b0;
  endtask

  // Returns at the negedge of the pkt_done cycle (or after the bound expires).
  task automatic wait_done(input int t0, input string name);
    bit found = 1'b0;
    for (int i = 0; i < PKT_CYC + 200; i++) begin
      @(negedge clk_in);
      if (pkt_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      check({name, "_cycles"}, cyc - t0, PKT_CYC);
      check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic quiet(input int n, input string name);
    bit bad = 1'b0;
    repeat (n) begin
      @(negedge clk_in);
      if (tx !== 1'b1 || busy !== 1'b0 || pkt_done !== 1'b0) bad = 1'b1;
    end
    check(name, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    bit saw_done;
    logic [0:6][7:0] pa, pb;

    vecs[0] = '{12'd487,  12'd362,  4'd3, 4'd5, {8'hA5, 8'h01, 8'hE7, 8'h01, 8'h6A, 8'h35, 8'hB8}};
    vecs[1] = '{12'hFFF,  12'h000,  4'hF, 4'hF, {8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h0F}};
    vecs[2] = '{12'h000,  12'h000,  4'h0, 4'h0, {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{12'h800,  12'h0AB,  4'h1, 4'hA, {8'hA5, 8'h08, 8'h00, 8'h00, 8'hAB, 8'h1A, 8'hB9}};
    vecs[4] = '{12'h123,  12'h456,  4'h7, 4'h9, {8'hA5, 8'h01, 8'h23, 8'h04, 8'h56, 8'h79, 8'h09}};

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    quiet(40, "idle_no_tick");

    // Table-driven packets
    for (int v = 0; v < 5; v++) begin
      push_bytes(vecs[v].b);
      pulse_tick(vecs[v].x, vecs[v].y, vecs[v].s1, vecs[v].s2);
      t0 = cyc;
      check("start_bit_next_cycle", {31'd0, tx}, 32'd0);
      check("busy_on_accept", {31'd0, busy}, 32'd1);
      check("no_overrun_on_accept", {31'd0, overrun}, 32'd0);
      wait_done(t0, "vec_pkt");
      @(negedge clk_in);
      check("pkt_done_one_cycle", {31'd0, pkt_done}, 32'd0);
      check("vec_all_bytes_seen", exp_q.size(), 32'd0);
      repeat (5) @(negedge clk_in);
    end

    // Snapshot: inputs changing right after the tick must not leak in
    push_bytes(vecs[0].b);
    pulse_tick(12'd487, 12'd362, 4'd3, 4'd5);
    t0 = cyc;
    xpos_ball      = 12'd100;
    ypos_ball      = 12'd7;
    player_1_score = 4'd9;
    wait_done(t0, "snap_pkt");
    check("snap_all_bytes_seen", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk_in);

    // Overrun: a tick mid-packet is dropped and flagged
    pa = model(12'h2AA, 12'h155, 4'd9, 4'd6);
    push_bytes(pa);
    pulse_tick(12'h2AA, 12'h155, 4'd9, 4'd6);
    t0 = cyc;
    repeat (300) @(negedge clk_in);
    xpos_ball  = 12'h0F0;
    frame_tick = 1'b1;
    @(posedge clk_in); #1;
    frame_tick = 1'b0;
    check("overrun_pulse", {31'd0, overrun}, 32'd1);
    @(posedge clk_in); #1;
    check("overrun_one_cycle", {31'd0, overrun}, 32'd0);
    wait_done(t0, "ovr_pkt");
    quiet(200, "ovr_no_second_pkt");
    check("ovr_all_bytes_seen", exp_q.size(), 32'd0);

    // Tick in the pkt_done cycle chains the next packet
    pa = model(12'h0C3, 12'h3C0, 4'd2, 4'd4);
    pb = model(12'hA5A, 12'h5A5, 4'd8, 4'd1);
    push_bytes(pa);
    pulse_tick(12'h0C3, 12'h3C0, 4'd2, 4'd4);
    t0 = cyc;
    wait_done(t0, "b2b_first");
    xpos_ball      = 12'hA5A;
    ypos_ball      = 12'h5A5;
    player_1_score = 4'd8;
    player_2_score = 4'd1;
    frame_tick     = 1'b1;
    push_bytes(pb);
    @(posedge clk_in); #1;
    frame_tick = 1'b0;
    t1 = cyc;
    check("b2b_start_next_cycle", {31'd0, tx}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_no_overrun", {31'd0, overrun}, 32'd0);
    wait_done(t1, "b2b_second");
    check("b2b_all_bytes_seen", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk_in);

    // Reset in the middle of B3
    push_bytes(vecs[0].b);
    pulse_tick(12'd487, 12'd362, 4'd3, 4'd5);
    repeat (500) @(negedge clk_in);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tx_high", {31'd0, tx}, 32'd1);
    check("midrst_busy_low", {31'd0, busy}, 32'd0);
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk_in);
      if (pkt_done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk_in);
      if (pkt_done !== 1'b0) saw_done = 1'b1;
    end
    check("midrst_no_pkt_done", {31'd0, saw_done}, 32'd0);
    quiet(20, "midrst_idle_after_release");
    push_bytes(vecs[0].b);
    pulse_tick(12'd487, 12'd362, 4'd3, 4'd5);
    t0 = cyc;
    check("postrst_start_bit", {31'd0, tx}, 32'd0);
    wait_done(t0, "postrst_pkt");
    check("postrst_all_bytes_seen", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk_in);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
